// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared size encodings and FSM state type for the load/store unit
package mips_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request/response and memory-side signal bundle
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // CPU side plus the memory model that answers reads
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           MemRead, MemWrite, mem_address, mem_wdata
  );

  // The load/store unit itself
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           MemRead, MemWrite, mem_address, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - big-endian lane extract (with extension) and store merge
module lsu_byte_lane
  import mips_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane; offset 0 is the most significant byte
  always_comb begin
    byte_sel = 8'h00;
    case (offset_i)
      2'd0: byte_sel = rdata_i[31:24];
      2'd1: byte_sel = rdata_i[23:16];
      2'd2: byte_sel = rdata_i[15:8];
      2'd3: byte_sel = rdata_i[7:0];
      default: byte_sel = 8'h00;
    endcase
    half_sel = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  // Extend the selected lane; word loads pass straight through
  always_comb begin
    load_data_o = 32'h0;
    case (size_i)
      SZ_BYTE: load_data_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: load_data_o = rdata_i;
      default: load_data_o = 32'h0;
    endcase
  end

  // Replace only the addressed lanes of the old word with the store data
  always_comb begin
    merged_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        case (offset_i)
          2'd0: merged_o[31:24] = wdata_i[7:0];
          2'd1: merged_o[23:16] = wdata_i[7:0];
          2'd2: merged_o[15:8]  = wdata_i[7:0];
          2'd3: merged_o[7:0]   = wdata_i[7:0];
          default: merged_o = rdata_i;
        endcase
      end
      SZ_HALF: begin
        if (offset_i[1]) merged_o[15:0] = wdata_i;
        else             merged_o[31:16] = wdata_i;
      end
      default: merged_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store FSM with RMW sub-word stores; LSU_BOUNDS_CHECK_EN adds a bounds fault
module load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1096
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  lsu_state_t  state_q;
  logic [1:0]  offset_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        req_fault;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  lsu_byte_lane u_lane (
    .rdata_i     (bus.mem_rdata),
    .offset_i    (offset_q),
    .size_i      (size_q),
    .unsigned_i  (unsigned_q),
    .wdata_i     (wdata_q),
    .load_data_o (lane_load),
    .merged_o    (lane_merged)
  );

  // Classify the incoming request as faulting (misaligned, reserved size, out of range)
  always_comb begin
    req_fault = 1'b0;
    case (bus.req_size)
      SZ_BYTE: req_fault = 1'b0;
      SZ_HALF: req_fault = bus.req_addr[0];
      SZ_WORD: req_fault = |bus.req_addr[1:0];
      default: req_fault = 1'b1;
    endcase
`ifdef LSU_BOUNDS_CHECK_EN
    if (({1'b0, bus.req_addr[31:2], 2'b00} + 33'd3) >= 33'(MEM_BYTES)) req_fault = 1'b1;
`endif
  end

  // Request sequencing: accept, memory phases, one-cycle response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      offset_q      <= 2'd0;
      size_q        <= SZ_BYTE;
      unsigned_q    <= 1'b0;
      we_q          <= 1'b0;
      wdata_q       <= 16'h0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'h0;
      mem_wdata_q   <= 32'h0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            offset_q      <= bus.req_addr[1:0];
            size_q        <= bus.req_size;
            unsigned_q    <= bus.req_unsigned;
            we_q          <= bus.req_we;
            wdata_q       <= bus.req_wdata[15:0];
            mem_address_q <= {bus.req_addr[31:2], 2'b00};
            if (req_fault) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else if (bus.req_we && bus.req_size == SZ_WORD) begin
              state_q     <= WRITE;
              mem_write_q <= 1'b1;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state_q    <= READ;
              mem_read_q <= 1'b1;
            end
          end
        end
        READ: begin
          mem_read_q <= 1'b0;
          if (we_q) begin
            state_q     <= WRITE;
            mem_write_q <= 1'b1;
            mem_wdata_q <= lane_merged;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= lane_load;
          end
        end
        WRITE: begin
          state_q      <= RESP;
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.MemRead     = mem_read_q;
  assign bus.MemWrite    = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench with byte-array reference model
module tb_load_store_unit;

  localparam int MEM_BYTES = 1096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // memory device answering the DUT, plus backdoor loader
  logic [31:0] dev_mem [0:511];
  logic        bd_we = 1'b0;
  logic [8:0]  bd_idx = 9'd0;
  logic [31:0] bd_data = 32'h0;
  int          wr_pulses = 0;

  assign bus.mem_rdata = dev_mem[bus.mem_address[10:2]];

  always @(posedge clk) begin
    if (bd_we) dev_mem[bd_idx] <= bd_data;
    else if (bus.MemWrite) dev_mem[bus.mem_address[10:2]] <= bus.mem_wdata;
    if (bus.MemWrite) wr_pulses <= wr_pulses + 1;
  end

  // reference model: flat byte array, big-endian
  logic [7:0] ref_mem [0:2047];

  int total = 0;
  int bad = 0;

  logic [31:0] r_rdata, r_addr, r_wdata;
  logic        r_err, r_both;
  int          r_lat, r_nrd, r_nwr;

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[idx*4], ref_mem[idx*4+1], ref_mem[idx*4+2], ref_mem[idx*4+3]};
  endfunction

  function automatic void ref_access(input logic we, input logic [1:0] sz, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic err,
                                     output int lat, output int nrd, output int nwr);
    int nb;
    logic [31:0] v, half;
    nb  = 1 << sz;
    err = (sz == 2'd3) || ((addr % nb) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    if ((addr / 4) * 4 + 3 >= MEM_BYTES) err = 1'b1;
`endif
    rd = 32'h0; lat = 1; nrd = 0; nwr = 0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = 8'(wd >> (8 * (nb - 1 - i)));
      nwr = 1;
      nrd = (nb < 4) ? 1 : 0;
      lat = (nb < 4) ? 3 : 2;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[int'(addr) + i]);
      if (!uns && nb < 4) begin
        half = 32'd1 << (8 * nb - 1);
        if (v >= half) v = v - (half << 1);
      end
      rd = v; nrd = 1; lat = 2;
    end
  endfunction

  task automatic set_word(input int idx, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_mem[idx*4 + i] = 8'(w >> (8 * (3 - i)));
    @(negedge clk);
    bd_idx = 9'(idx); bd_data = w; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // issue one request, scramble inputs after accept, observe until response
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL ready_idle got=%b exp=1", bus.req_ready); end
    total++;
    if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL resp_one_cycle got=%b exp=0", bus.resp_valid); end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_unsigned = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
    r_lat = 0; r_nrd = 0; r_nwr = 0; r_both = 1'b0; r_rdata = 32'h0; r_err = 1'b0;
    r_addr = 32'h0; r_wdata = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.MemRead)  begin r_nrd++; r_addr = bus.mem_address; end
      if (bus.MemWrite) begin r_nwr++; r_addr = bus.mem_address; r_wdata = bus.mem_wdata; end
      if (bus.MemRead && bus.MemWrite) r_both = 1'b1;
      if (bus.resp_valid) begin
        r_lat = c; r_rdata = bus.resp_rdata; r_err = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.req_ready !== 1'b1)     begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0)    begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
    total++; if (bus.resp_err !== 1'b0)      begin bad++; $display("FAIL rst_resp_err got=%b exp=0", bus.resp_err); end
    total++; if (bus.resp_rdata !== 32'h0)   begin bad++; $display("FAIL rst_resp_rdata got=%h exp=0", bus.resp_rdata); end
    total++; if (bus.MemRead !== 1'b0)       begin bad++; $display("FAIL rst_memread got=%b exp=0", bus.MemRead); end
    total++; if (bus.MemWrite !== 1'b0)      begin bad++; $display("FAIL rst_memwrite got=%b exp=0", bus.MemWrite); end
    total++; if (bus.mem_address !== 32'h0)  begin bad++; $display("FAIL rst_mem_address got=%h exp=0", bus.mem_address); end
    total++; if (bus.mem_wdata !== 32'h0)    begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", bus.mem_wdata); end
    for (int i = 0; i < 512; i++) set_word(i, $urandom);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] d_rd; logic d_err; int d_lat, d_nrd, d_nwr;
    set_word(0, 32'h0000001C);
    do_req(1'b0, 2'd0, 1'b0, 32'd3, 32'h0);
    total++; if (r_rdata !== 32'h0000001C) begin bad++; $display("FAIL lb3_rdata got=%h exp=0000001c", r_rdata); end
    total++; if (r_lat !== 2)  begin bad++; $display("FAIL lb3_latency got=%0d exp=2", r_lat); end
    total++; if (r_nrd !== 1 || r_nwr !== 0 || r_addr !== 32'h0) begin bad++; $display("FAIL lb3_mem got rd=%0d wr=%0d addr=%h exp rd=1 wr=0 addr=0", r_nrd, r_nwr, r_addr); end

    ref_access(1'b1, 2'd0, 1'b0, 32'd1, 32'hFF, d_rd, d_err, d_lat, d_nrd, d_nwr);
    do_req(1'b1, 2'd0, 1'b0, 32'd1, 32'h000000FF);
    total++; if (r_wdata !== 32'h00FF001C) begin bad++; $display("FAIL sb1_wdata got=%h exp=00ff001c", r_wdata); end
    total++; if (r_nrd !== 1 || r_nwr !== 1 || r_addr !== 32'h0) begin bad++; $display("FAIL sb1_mem got rd=%0d wr=%0d addr=%h exp rd=1 wr=1 addr=0", r_nrd, r_nwr, r_addr); end
    total++; if (r_lat !== 3 || r_rdata !== 32'h0) begin bad++; $display("FAIL sb1_resp got lat=%0d rdata=%h exp lat=3 rdata=0", r_lat, r_rdata); end
    do_req(1'b0, 2'd1, 1'b0, 32'd0, 32'h0);
    total++; if (r_rdata !== 32'h000000FF) begin bad++; $display("FAIL lh0_rdata got=%h exp=000000ff", r_rdata); end

    set_word(6, 32'h0000002C);
    ref_access(1'b1, 2'd0, 1'b0, 32'd27, 32'hAC, d_rd, d_err, d_lat, d_nrd, d_nwr);
    do_req(1'b1, 2'd0, 1'b0, 32'd27, 32'h000000AC);
    do_req(1'b0, 2'd0, 1'b0, 32'd27, 32'h0);
    total++; if (r_rdata !== 32'hFFFFFFAC) begin bad++; $display("FAIL lb27_rdata got=%h exp=ffffffac", r_rdata); end
    do_req(1'b0, 2'd0, 1'b1, 32'd27, 32'h0);
    total++; if (r_rdata !== 32'h000000AC) begin bad++; $display("FAIL lbu27_rdata got=%h exp=000000ac", r_rdata); end

    do_req(1'b0, 2'd1, 1'b0, 32'd1, 32'h0);
    total++; if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_lat !== 1) begin bad++; $display("FAIL lh1_fault got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=1", r_err, r_rdata, r_lat); end
    total++; if (r_nrd !== 0 || r_nwr !== 0) begin bad++; $display("FAIL lh1_nomem got rd=%0d wr=%0d exp 0 0", r_nrd, r_nwr); end
    do_req(1'b1, 2'd2, 1'b0, 32'd6, 32'h12345678);
    total++; if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_lat !== 1) begin bad++; $display("FAIL sw6_fault got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=1", r_err, r_rdata, r_lat); end
    total++; if (r_nrd !== 0 || r_nwr !== 0) begin bad++; $display("FAIL sw6_nomem got rd=%0d wr=%0d exp 0 0", r_nrd, r_nwr); end
    do_req(1'b0, 2'd3, 1'b0, 32'd8, 32'h0);
    total++; if (r_err !== 1'b1 || r_nrd !== 0) begin bad++; $display("FAIL rsvd_size got err=%b rd=%0d exp err=1 rd=0", r_err, r_nrd); end
  endtask

  task automatic test_bounds();
    logic exp_err;
`ifdef LSU_BOUNDS_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_req(1'b0, 2'd2, 1'b0, 32'd1096, 32'h0);
    total++; if (r_err !== exp_err) begin bad++; $display("FAIL lw1096_err got=%b exp=%b", r_err, exp_err); end
    total++; if (r_nrd !== (exp_err ? 0 : 1)) begin bad++; $display("FAIL lw1096_reads got=%0d exp=%0d", r_nrd, exp_err ? 0 : 1); end
    total++; if (!exp_err && r_rdata !== ref_word(274)) begin bad++; $display("FAIL lw1096_rdata got=%h exp=%h", r_rdata, ref_word(274)); end
  endtask

  task automatic test_random();
    logic we, uns, e_err; logic [1:0] sz; logic [31:0] addr, wd, e_rd;
    int sel, e_lat, e_nrd, e_nwr;
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 9);
      sz  = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      we  = 1'($urandom); uns = 1'($urandom); wd = $urandom;
      addr = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) addr = addr & ~((32'd1 << sz) - 32'd1);
      ref_access(we, sz, uns, addr, wd, e_rd, e_err, e_lat, e_nrd, e_nwr);
      do_req(we, sz, uns, addr, wd);
      total++; if (r_rdata !== e_rd)  begin bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, r_rdata, e_rd); end
      total++; if (r_err !== e_err)   begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, r_err, e_err); end
      total++; if (r_lat !== e_lat)   begin bad++; $display("FAIL rnd_latency n=%0d got=%0d exp=%0d", n, r_lat, e_lat); end
      total++; if (r_nrd !== e_nrd || r_nwr !== e_nwr) begin bad++; $display("FAIL rnd_mem_ops n=%0d got rd=%0d wr=%0d exp rd=%0d wr=%0d", n, r_nrd, r_nwr, e_nrd, e_nwr); end
      total++; if (r_both !== 1'b0)   begin bad++; $display("FAIL rnd_rd_wr_overlap n=%0d got=1 exp=0", n); end
      if (e_nrd + e_nwr > 0) begin
        total++; if (r_addr !== (addr & ~32'd3)) begin bad++; $display("FAIL rnd_mem_address n=%0d got=%h exp=%h", n, r_addr, addr & ~32'd3); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int wr_before;
    logic [31:0] w0;
    w0 = ref_word(0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd2; bus.req_wdata = 32'h0000005A;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.MemRead !== 1'b1) begin bad++; $display("FAIL rstmid_in_read got=%b exp=1", bus.MemRead); end
    wr_before = wr_pulses;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", bus.req_ready); end
    for (int c = 0; c < 4; c++) begin
      total++; if (bus.resp_valid !== 1'b0 || bus.MemWrite !== 1'b0) begin bad++; $display("FAIL rstmid_quiet c=%0d got resp=%b wr=%b exp 0 0", c, bus.resp_valid, bus.MemWrite); end
      @(negedge clk);
    end
    total++; if (wr_pulses !== wr_before) begin bad++; $display("FAIL rstmid_no_write got=%0d exp=%0d", wr_pulses, wr_before); end
    total++; if (dev_mem[0] !== w0) begin bad++; $display("FAIL rstmid_word0 got=%h exp=%h", dev_mem[0], w0); end
  endtask

  task automatic test_memory_image();
    for (int i = 0; i < 512; i++) begin
      total++;
      if (dev_mem[i] !== ref_word(i)) begin bad++; $display("FAIL mem_image idx=%0d got=%h exp=%h", i, dev_mem[i], ref_word(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bounds();
    test_random();
    test_reset_mid();
    test_memory_image();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1096, giving the data memory size in bytes for bounds checking.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  CPU access request.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have ports req_addr and req_wdata  input  32 each  byte address and store data (right-justified).
REQ-010 SHALL have ports resp_valid  output  1, resp_rdata  output  32, resp_err  output  1: completion, load result, fault.
REQ-011 SHALL have memory-side ports MemRead and MemWrite  output  1 each, mem_address  output  32, mem_wdata  output  32, mem_rdata  input  32 (combinational read data).

Function
REQ-012 SHALL use big-endian lanes: byte offset 0 = bits 31:24, offset 3 = bits 7:0; mem_address is always word-aligned (req_addr & ~3).
REQ-013 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE; a request is accepted on req_valid & req_ready.
REQ-014 Load accept SHALL go IDLE->READ (MemRead=1, rdata latched at end of cycle)->RESP; resp_valid 2 cycles after accept.
REQ-015 Word store SHALL go IDLE->WRITE (MemWrite=1, mem_wdata=req_wdata)->RESP.
REQ-016 Byte/half store SHALL perform read-modify-write: READ -> WRITE with merged word (only addressed lanes replaced) -> RESP; resp_valid 3 cycles after accept.
REQ-017 MemRead and MemWrite SHALL never be high together; mem_address/mem_wdata SHALL be registered and stable throughout WRITE.
REQ-018 Loads SHALL extract the addressed lane(s) and sign- or zero-extend per req_unsigned; word loads ignore req_unsigned.
REQ-019 Misalignment (half at odd address, word not multiple of 4) or req_size=11 SHALL skip memory access, go IDLE->RESP, with resp_err=1 and resp_rdata=0.
REQ-020 RESP SHALL last exactly one cycle (resp_valid=1) then return to IDLE; resp_rdata=0 for stores.
REQ-021 req_* inputs SHALL be captured at accept; changes afterwards SHALL not affect the operation.

Reset
REQ-022 rst SHALL force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0, MemWrite=0, mem_address=0, mem_wdata=0 on the next edge.
REQ-023 rst asserted mid-operation SHALL abandon it with no response; an abandoned READ-phase store SHALL issue no write.

Configuration
REQ-024 With LSU_BOUNDS_CHECK_EN defined, any access where aligned address + 3 >= MEM_BYTES SHALL be treated as a fault per REQ-019.
REQ-025 Without LSU_BOUNDS_CHECK_EN, no bounds check SHALL exist and MEM_BYTES SHALL be unused.

Structure
REQ-026 Package mips_lsu_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-027 Lane extract/merge logic SHALL be a combinational sub-module lsu_byte_lane; FSM and registers stay in load_store_unit.

Verification
REQ-028 Memory word@0=0x0000001C; LB signed addr 3 -> resp_valid 2 cycles later, resp_rdata=0x0000001C, one MemRead pulse at address 0.
REQ-029 SB 0x000000FF at addr 1 -> MemRead then MemWrite at 0 with mem_wdata=0x00FF001C; following LH signed addr 0 -> 0x000000FF.
REQ-030 Memory word@24=0x0000002C, byte@27 set to 0xAC; LB signed addr 27 -> 0xFFFFFFAC; LBU -> 0x000000AC.
REQ-031 LH addr 1 and SW addr 6 -> resp_err=1, resp_rdata=0, no MemRead/MemWrite asserted.
REQ-032 With LSU_BOUNDS_CHECK_EN, LW addr 1096 -> resp_err=1; without it, no error raised.
REQ-033 rst asserted in READ of SB addr 2 -> no MemWrite, word@0 unchanged, req_ready=1 the cycle after reset.
